// File: rtl/cnn_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : cnn_pkg
// Description : Shared widths, types and the ReLU + requantisation helper
//               for the CNN post-processing blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int ACC_W = 32;  // PE accumulator width
    localparam int PIX_W = 8;   // default unsigned pixel width

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic        [PIX_W-1:0] pix_t;

    // Pooling row phase: the top row of a 2x2 window fills the line buffer,
    // the bottom row consumes it and produces pooled pixels.
    typedef enum logic [0:0] {
        ROW_TOP = 1'b0,
        ROW_BOT = 1'b1
    } row_state_t;

    // ReLU followed by round-half-up right shift. The result is returned
    // unclipped in ACC_W+1 bits so the caller can detect and saturate to its
    // own output width. A positive input plus the rounding bias never exceeds
    // 2^32, so ACC_W+1 bits cannot overflow.
    function automatic logic [ACC_W:0] relu_requant(input acc_t x, input int unsigned shift);
        logic [ACC_W:0] v_half;
        logic [ACC_W:0] v_sum;
        v_half = {{ACC_W{1'b0}}, 1'b1} << (shift - 1);
        v_sum  = {1'b0, x} + v_half;
        if (x <= 0) begin
            return '0;
        end
        return v_sum >> shift;
    endfunction

endpackage : cnn_pkg
`default_nettype wire

// File: rtl/pool_line_buf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pool_line_buf
// Description : Line buffer holding the horizontal maxima of the top row of
//               each 2x2 pooling window. One synchronous write port, one
//               asynchronous (combinational) read port. Contents are not
//               reset: every slot is written in the top row before the bottom
//               row reads it.
// Ports       : clk_i      - clock
//               wr_en_i    - write strobe
//               wr_addr_i  - write slot
//               wr_data_i  - write data
//               rd_addr_i  - read slot
//               rd_data_o  - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module pool_line_buf
    import cnn_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = PIX_W,
    parameter int AW    = 1
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : pool_line_buf
`default_nettype wire

// File: rtl/relu_quant_pool.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : relu_quant_pool
// Description : ReLU + requantisation of PE accumulator results followed by
//               2x2 / stride-2 max pooling over a streamed feature map.
//               Stage 1 (registered): ReLU, rounding shift, saturation.
//               Stage 2 (registered): horizontal max, line buffer, vertical
//               max. Window output appears two cycles after the in_valid of
//               its bottom-right input. No backpressure.
// Ports       : clk       - clock
//               rst       - asynchronous active-high reset
//               clear     - synchronous flush (wins over in_valid)
//               in_valid  - accumulator beat valid
//               in_data   - signed accumulator value
//               in_last   - last column marker, checked against counter
//               out_valid - pooled pixel pulse
//               out_data  - pooled pixel, held while out_valid is low
//               out_last  - last pooled pixel of an output row
//               row_err   - sticky in_last/column disagreement
//               sat_cnt   - saturation event count (RQP_SAT_CNT_EN only)
// Options     : RQP_SAT_CNT_EN - adds the 16-bit saturating sat_cnt output
// Revision    : 1.0 - initial release
// ============================================================================
module relu_quant_pool
    import cnn_pkg::*;
#(
    parameter int ROW_LEN = 3,
    parameter int SHIFT   = 14,
    parameter int OUT_W   = PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  acc_t             in_data,
    input  logic             in_last,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             row_err
`ifdef RQP_SAT_CNT_EN
    ,
    output logic [15:0]      sat_cnt
`endif
);

    localparam int c_col_w = $clog2(ROW_LEN);
    localparam int c_slots = ROW_LEN / 2;
    localparam int c_aw    = (c_slots > 1) ? $clog2(c_slots) : 1;

    localparam logic [c_col_w-1:0] c_last_col  = c_col_w'(ROW_LEN - 1);
    localparam logic [c_col_w-1:0] c_col_one   = c_col_w'(1);
    localparam logic [c_aw-1:0]    c_last_slot = c_aw'(c_slots - 1);
    localparam bit                 c_odd_len   = (ROW_LEN % 2) == 1;
    localparam logic [ACC_W:0]     c_sat_max   = {{(ACC_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_col_w-1:0] col_q,      col_d;
    row_state_t         row_q,      row_d;
    logic               s1_valid_q, s1_valid_d;
    logic [OUT_W-1:0]   s1_pix_q,   s1_pix_d;
    logic [c_col_w-1:0] s1_col_q,   s1_col_d;
    row_state_t         s1_row_q,   s1_row_d;
    logic [OUT_W-1:0]   h_q,        h_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q,  out_data_d;
    logic               out_last_q,  out_last_d;
    logic               row_err_q;

    // ------------------------------------------------------------------
    // Stage 1 combinational: ReLU, rounding shift, saturation
    // ------------------------------------------------------------------
    logic [ACC_W:0]   w_r;
    logic             w_sat;
    logic [OUT_W-1:0] w_pix;
    logic             w_take;
    logic             w_col_end;

    assign w_r       = relu_requant(in_data, SHIFT);
    assign w_sat     = w_r > c_sat_max;
    assign w_pix     = w_sat ? {OUT_W{1'b1}} : w_r[OUT_W-1:0];
    assign w_take    = in_valid & ~clear;
    assign w_col_end = (col_q == c_last_col);

    // ------------------------------------------------------------------
    // Stage 2 combinational: horizontal and vertical max
    // ------------------------------------------------------------------
    logic [c_aw-1:0]  w_slot;
    logic             w_odd;
    logic             w_discard;
    logic [OUT_W-1:0] w_hmax;
    logic [OUT_W-1:0] w_lb_rd;
    logic [OUT_W-1:0] w_pool;
    logic             w_lb_we;

    assign w_slot    = c_aw'(s1_col_q >> 1);
    assign w_odd     = s1_col_q[0];
    // With an odd row length the trailing even column has no partner and is
    // dropped (floor pooling).
    assign w_discard = c_odd_len && (s1_col_q == c_last_col);
    assign w_hmax    = (s1_pix_q > h_q) ? s1_pix_q : h_q;
    assign w_pool    = (w_hmax > w_lb_rd) ? w_hmax : w_lb_rd;
    assign w_lb_we   = s1_valid_q & w_odd & (s1_row_q == ROW_TOP) & ~clear;

    pool_line_buf #(
        .DEPTH (c_slots),
        .WIDTH (OUT_W),
        .AW    (c_aw)
    ) u_line_buf (
        .clk_i     (clk),
        .wr_en_i   (w_lb_we),
        .wr_addr_i (w_slot),
        .wr_data_i (w_hmax),
        .rd_addr_i (w_slot),
        .rd_data_o (w_lb_rd)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        s1_valid_d  = 1'b0;
        s1_pix_d    = s1_pix_q;
        s1_col_d    = s1_col_q;
        s1_row_d    = s1_row_q;
        h_d         = h_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_last_d  = 1'b0;

        if (clear) begin
            col_d      = '0;
            row_d      = ROW_TOP;
            s1_pix_d   = '0;
            s1_col_d   = '0;
            s1_row_d   = ROW_TOP;
            h_d        = '0;
            out_data_d = '0;
        end else begin
            // The counter and row phase advance as a beat is accepted; the
            // beat carries its own column and row into stage 1 so stage 2
            // never sees the already-advanced values.
            if (in_valid) begin
                s1_valid_d = 1'b1;
                s1_pix_d   = w_pix;
                s1_col_d   = col_q;
                s1_row_d   = row_q;
                if (w_col_end) begin
                    col_d = '0;
                    row_d = (row_q == ROW_TOP) ? ROW_BOT : ROW_TOP;
                end else begin
                    col_d = col_q + c_col_one;
                end
            end

            if (s1_valid_q) begin
                if (!w_odd) begin
                    if (!w_discard) begin
                        h_d = s1_pix_q;
                    end
                end else if (s1_row_q == ROW_BOT) begin
                    out_valid_d = 1'b1;
                    out_data_d  = w_pool;
                    out_last_d  = (w_slot == c_last_slot);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= ROW_TOP;
            s1_valid_q  <= 1'b0;
            s1_pix_q    <= '0;
            s1_col_q    <= '0;
            s1_row_q    <= ROW_TOP;
            h_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            s1_valid_q  <= s1_valid_d;
            s1_pix_q    <= s1_pix_d;
            s1_col_q    <= s1_col_d;
            s1_row_q    <= s1_row_d;
            h_q         <= h_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Sticky framing error; survives clear so software can inspect it after
    // flushing the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_err_q <= 1'b0;
        end else if (w_take && (in_last != w_col_end)) begin
            row_err_q <= 1'b1;
        end
    end

`ifdef RQP_SAT_CNT_EN
    logic [15:0] sat_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt_q <= '0;
        end else if (clear) begin
            sat_cnt_q <= '0;
        end else if (w_take && w_sat && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_cnt = sat_cnt_q;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign row_err   = row_err_q;

endmodule : relu_quant_pool
`default_nettype wire

// File: tb/tb_relu_quant_pool.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_relu_quant_pool
// Description : Self-checking bench. DUT A uses ROW_LEN=4, DUT B ROW_LEN=3.
//               A behavioural model (whole-row arrays, plain arithmetic)
//               predicts every pooled pixel, its out_last flag and its
//               arrival cycle. Options: RQP_SAT_CNT_EN adds sat_cnt checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relu_quant_pool;

    localparam int L  = 4;
    localparam int SH = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_clear, a_in_valid, a_in_last;
    logic [31:0] a_in_data;
    logic        a_out_valid, a_out_last, a_row_err;
    logic [7:0]  a_out_data;
    logic        b_clear, b_in_valid, b_in_last;
    logic [31:0] b_in_data;
    logic        b_out_valid, b_out_last, b_row_err;
    logic [7:0]  b_out_data;
`ifdef RQP_SAT_CNT_EN
    logic [15:0] a_sat_cnt, b_sat_cnt;
`endif

    relu_quant_pool #(.ROW_LEN(L), .SHIFT(SH), .OUT_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .clear(a_clear), .in_valid(a_in_valid),
        .in_data(a_in_data), .in_last(a_in_last), .out_valid(a_out_valid),
        .out_data(a_out_data), .out_last(a_out_last), .row_err(a_row_err)
`ifdef RQP_SAT_CNT_EN
        , .sat_cnt(a_sat_cnt)
`endif
    );

    relu_quant_pool #(.ROW_LEN(3), .SHIFT(SH), .OUT_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .clear(b_clear), .in_valid(b_in_valid),
        .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid),
        .out_data(b_out_data), .out_last(b_out_last), .row_err(b_row_err)
`ifdef RQP_SAT_CNT_EN
        , .sat_cnt(b_sat_cnt)
`endif
    );

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int     data;
        bit     last;
        longint cyc;
    } exp_t;

    exp_t expq[$];
    exp_t bq[$];
    int   m_col, m_sat;
    bit   m_bot, m_err;
    int   m_top[L];
    int   m_btm[L];

    function automatic int model_pix(input int x, output bit sat);
        longint r;
        sat = 1'b0;
        if (x <= 0) return 0;
        r = (longint'(x) + (longint'(1) << (SH - 1))) / (longint'(1) << SH);
        if (r > 255) begin
            sat = 1'b1;
            return 255;
        end
        return int'(r);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset(input bit hard);
        m_col = 0;
        m_bot = 1'b0;
        m_sat = 0;
        expq.delete();
        if (hard) m_err = 1'b0;
    endtask

    task automatic a_beat(input int d, input bit lst);
        bit   s;
        int   p;
        exp_t e;
        p = model_pix(d, s);
        if (s && m_sat < 65535) m_sat++;
        if (lst != (m_col == L - 1)) m_err = 1'b1;
        if (!m_bot) begin
            m_top[m_col] = p;
        end else begin
            m_btm[m_col] = p;
            if (m_col % 2 == 1) begin
                e.data = max2(max2(m_top[m_col-1], m_top[m_col]),
                              max2(m_btm[m_col-1], m_btm[m_col]));
                e.last = (m_col / 2 == L / 2 - 1);
                e.cyc  = cyc + 2;
                expq.push_back(e);
            end
        end
        if (m_col == L - 1) begin
            m_col = 0;
            m_bot = ~m_bot;
        end else begin
            m_col++;
        end
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_last  = lst;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
    endtask

    task automatic a_send(input int d);
        a_beat(d, m_col == L - 1);
    endtask

    task automatic a_row(input int p0, input int p1, input int p2, input int p3);
        a_send(p0 * 16384);
        a_send(p1 * 16384);
        a_send(p2 * 16384);
        a_send(p3 * 16384);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic int rand_data();
        case ($urandom_range(0, 3))
            0:       return -int'($urandom_range(1, 100000));
            1:       return int'($urandom_range(0, 300)) * 16384 + int'($urandom_range(0, 16383));
            2:       return int'($urandom());
            default: return int'($urandom_range(0, 300)) * 16384 + 8192 - int'($urandom_range(0, 1));
        endcase
    endfunction

    // ---------------- output monitors ----------------
    int         n_out_a     = 0;
    int         last_a      = 0;
    bit         last_a_last = 1'b0;
    bit         hold_en     = 1'b0;
    logic [7:0] prev_a      = '0;

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_out_valid === 1'b1) begin
            n_out_a++;
            last_a      = int'(a_out_data);
            last_a_last = a_out_last;
            if (expq.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("pool_data", a_out_data, e.data);
                chk("pool_last", a_out_last, e.last);
                chk("pool_latency", cyc, e.cyc);
            end
        end else if (hold_en) begin
            chk("hold_data", a_out_data, prev_a);
            chk("idle_last", a_out_last, 0);
        end
        prev_a = a_out_data;
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_out_valid === 1'b1) begin
            e.data = int'(b_out_data);
            e.last = b_out_last;
            e.cyc  = cyc;
            bq.push_back(e);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    typedef struct {
        int din;
        int pix;
    } vec_t;

    initial begin : main
        vec_t   tbl[12];
        longint bcyc;
        int     bv[6];
        int     n0;
`ifdef RQP_SAT_CNT_EN
        int     s0;
`endif
        tbl[0]  = '{-5, 0};
        tbl[1]  = '{0, 0};
        tbl[2]  = '{8192, 1};
        tbl[3]  = '{16384, 1};
        tbl[4]  = '{24575, 1};
        tbl[5]  = '{24576, 2};
        tbl[6]  = '{4169727, 254};
        tbl[7]  = '{4177920, 255};
        tbl[8]  = '{4186111, 255};
        tbl[9]  = '{4186112, 255};
        tbl[10] = '{32'h7FFFFFFF, 255};
        tbl[11] = '{32'h80000000, 0};

        rst = 1'b1;
        a_clear = 1'b0; a_in_valid = 1'b0; a_in_last = 1'b0; a_in_data = '0;
        b_clear = 1'b0; b_in_valid = 1'b0; b_in_last = 1'b0; b_in_data = '0;
        model_reset(1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_out_valid", a_out_valid, 0);
        chk("reset_out_data", a_out_data, 0);
        chk("reset_out_last", a_out_last, 0);
        chk("reset_row_err", a_row_err, 0);
`ifdef RQP_SAT_CNT_EN
        chk("reset_sat_cnt", a_sat_cnt, 0);
`endif

        // ROW_LEN=3: trailing column ignored, single output with out_last.
        bv = '{5, 6, 200, 1, 2, 3};
        bcyc = 0;
        for (int i = 0; i < 6; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = bv[i] * 16384;
            b_in_last  = (i % 3 == 2);
            if (i == 4) bcyc = cyc;
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            b_in_last  = 1'b0;
        end
        idle(4);
        chk("odd_len_out_count", bq.size(), 1);
        if (bq.size() >= 1) begin
            chk("odd_len_data", bq[0].data, 6);
            chk("odd_len_last", bq[0].last, 1);
            chk("odd_len_latency", bq[0].cyc, bcyc + 2);
        end
        chk("odd_len_row_err", b_row_err, 0);

        // Requantisation table, each value routed through window slot 0.
        for (int i = 0; i < 12; i++) begin
            a_send(tbl[i].din);
            a_send(-1); a_send(-1); a_send(-1);
            a_send(0); a_send(0);
            idle(3);
            chk("requant_table", last_a, tbl[i].pix);
            a_send(0); a_send(0);
            idle(2);
        end
`ifdef RQP_SAT_CNT_EN
        chk("sat_cnt_table", a_sat_cnt, m_sat);
        s0 = int'(a_sat_cnt);
        a_send(32'h7FFFFFFF);
        idle(1);
        chk("sat_cnt_increment", int'(a_sat_cnt) - s0, 1);
        a_send(0); a_send(0); a_send(0);
        a_row(0, 0, 0, 0);
        idle(3);
`endif

        // Basic 4-column pooling.
        n0 = n_out_a;
        a_row(1, 9, 3, 4);
        a_send(2 * 16384); a_send(5 * 16384);
        idle(3);
        chk("window0_data", last_a, 9);
        a_send(7 * 16384); a_send(0);
        idle(3);
        chk("window1_data", last_a, 7);
        chk("window1_last", last_a_last, 1);
        chk("window_count", n_out_a - n0, 2);

        // Clear together with in_valid: clear wins and the beat is dropped.
        a_send(50 * 16384); a_send(60 * 16384);
        a_clear = 1'b1; a_in_valid = 1'b1; a_in_data = 100 * 16384; a_in_last = 1'b0;
        @(posedge clk); #1;
        a_clear = 1'b0; a_in_valid = 1'b0;
        model_reset(1'b0);
        chk("clear_out_data", a_out_data, 0);
        n0 = n_out_a;
        a_row(10, 20, 30, 40);
        a_row(1, 2, 3, 4);
        idle(3);
        chk("after_clear_data", last_a, 40);
        chk("after_clear_count", n_out_a - n0, 2);

        // Misplaced in_last: sticky error, counting carries on unchanged.
        a_beat(5 * 16384, 1'b0);
        a_beat(6 * 16384, 1'b1);
        idle(1);
        chk("row_err_set", a_row_err, 1);
        a_send(7 * 16384); a_send(8 * 16384);
        a_row(1, 1, 1, 1);
        idle(3);
        chk("row_err_no_resync", last_a, 8);
        a_clear = 1'b1;
        @(posedge clk); #1;
        a_clear = 1'b0;
        model_reset(1'b0);
        chk("row_err_survives_clear", a_row_err, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset(1'b1);
        chk("row_err_rst", a_row_err, 0);

        // Asynchronous reset in the middle of a bottom row.
        a_row(3, 8, 1, 1);
        a_send(2 * 16384); a_send(4 * 16384);
        idle(3);
        chk("pre_async_data", last_a, 8);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_data", a_out_data, 0);
        chk("async_rst_out_valid", a_out_valid, 0);
        chk("async_rst_out_last", a_out_last, 0);
        model_reset(1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        n0 = n_out_a;
        a_row(7, 1, 2, 9);
        a_row(0, 0, 0, 0);
        idle(3);
        chk("post_async_data", last_a, 9);
        chk("post_async_count", n_out_a - n0, 2);

        // Randomised stream with gaps, checked against the model.
        hold_en = 1'b1;
        for (int p = 0; p < 16; p++) begin
            for (int b = 0; b < 2 * L; b++) begin
                idle(int'($urandom_range(0, 2)));
                a_send(rand_data());
            end
        end
        idle(4);
        hold_en = 1'b0;
        chk("random_row_err", a_row_err, m_err);
`ifdef RQP_SAT_CNT_EN
        chk("random_sat_cnt", a_sat_cnt, m_sat);
`endif
        chk("pending_outputs", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_relu_quant_pool
`default_nettype wire
